// File: rtl/vga_timing_core.sv
// Free-running VGA raster generator: sync pulses, visible window, beam
// coordinates, completed-frame counter and single-cycle line/frame/vblank strobes.
module vga_timing_core #(
    parameter int unsigned H_DISPLAY   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_DISPLAY   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter bit          SYNC_ACTIVE = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    output logic        hsync,
    output logic        vsync,
    output logic        display_on,
    output logic [9:0]  hpos,
    output logic [9:0]  vpos,
    output logic [15:0] frame_cnt,
    output logic        line_start,
    output logic        frame_start,
    output logic        vblank_start
);

    localparam int unsigned H_TOTAL    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL    = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_SYNC_BEG = H_DISPLAY + H_FRONT;
    localparam int unsigned H_SYNC_END = H_SYNC_BEG + H_SYNC;
    localparam int unsigned V_SYNC_BEG = V_DISPLAY + V_FRONT;
    localparam int unsigned V_SYNC_END = V_SYNC_BEG + V_SYNC;

    // Coordinates are 10 bits wide, so the raster must fit in 1024x1024.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
        $error("vga_timing_core: H_TOTAL or V_TOTAL exceeds 1024");
    end

    logic       h_wrap;
    logic       v_wrap;
    logic       vblank_load;
    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       hsync_next;
    logic       vsync_next;
    logic       display_next;

    // Next beam position and the outputs describing it, so registered
    // outputs line up with the coordinates loaded on the same edge.
    always_comb begin
        h_wrap       = (hpos == 10'(H_TOTAL - 1));
        v_wrap       = (vpos == 10'(V_TOTAL - 1));
        h_next       = h_wrap ? 10'd0 : hpos + 10'd1;
        v_next       = vpos;
        if (h_wrap) begin
            v_next = v_wrap ? 10'd0 : vpos + 10'd1;
        end
        vblank_load  = h_wrap && (v_next == 10'(V_DISPLAY));
        hsync_next   = (32'(h_next) >= H_SYNC_BEG && 32'(h_next) < H_SYNC_END)
                       ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_next   = (32'(v_next) >= V_SYNC_BEG && 32'(v_next) < V_SYNC_END)
                       ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        display_next = (32'(h_next) < H_DISPLAY) && (32'(v_next) < V_DISPLAY);
    end

    // Reset parks the beam on the last pixel so the first advance lands on (0,0).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hpos         <= 10'(H_TOTAL - 1);
            vpos         <= 10'(V_TOTAL - 1);
            hsync        <= ~SYNC_ACTIVE;
            vsync        <= ~SYNC_ACTIVE;
            display_on   <= 1'b0;
            frame_cnt    <= 16'd0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end else begin
            // Strobes update every clk so they never stretch across a stall.
            line_start   <= ce && h_wrap;
            frame_start  <= ce && h_wrap && v_wrap;
            vblank_start <= ce && vblank_load;
            if (ce) begin
                hpos       <= h_next;
                vpos       <= v_next;
                hsync      <= hsync_next;
                vsync      <= vsync_next;
                display_on <= display_next;
                if (vblank_load) begin
                    frame_cnt <= frame_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_core.sv
// Bench for vga_timing_core: a full-size 640x480 instance plus a shrunken raster
// (active-high sync) so whole frames fit in a short run; both follow one model.
module tb_vga_timing_core;

    logic clk;
    logic reset;
    logic ce;

    logic       hs_b, vs_b, de_b, ls_b, fs_b, vb_b;
    logic [9:0] hp_b, vp_b;
    logic [15:0] fc_b;
    logic       hs_s, vs_s, de_s, ls_s, fs_s, vb_s;
    logic [9:0] hp_s, vp_s;
    logic [15:0] fc_s;

    int checks   = 0;
    int failures = 0;

    // Beam-advance count since reset and whether the latest edge had ce=1.
    int          n;
    bit          adv;
    logic [15:0] bias_s;

    vga_timing_core dut_b (
        .clk(clk), .reset(reset), .ce(ce),
        .hsync(hs_b), .vsync(vs_b), .display_on(de_b),
        .hpos(hp_b), .vpos(vp_b), .frame_cnt(fc_b),
        .line_start(ls_b), .frame_start(fs_b), .vblank_start(vb_b)
    );

    vga_timing_core #(
        .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
        .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .SYNC_ACTIVE(1'b1)
    ) dut_s (
        .clk(clk), .reset(reset), .ce(ce),
        .hsync(hs_s), .vsync(vs_s), .display_on(de_s),
        .hpos(hp_s), .vpos(vp_s), .frame_cnt(fc_s),
        .line_start(ls_s), .frame_start(fs_s), .vblank_start(vb_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            n   <= 0;
            adv <= 1'b0;
        end else begin
            adv <= ce;
            if (ce) n <= n + 1;
        end
    end

    // Expected outputs after k advances: advance k lands on raster index k-1.
    function automatic logic [41:0] model(input int hd, input int hf, input int hs,
                                          input int hb, input int vd, input int vf,
                                          input int vs, input int vb, input bit act,
                                          input int k, input bit a, input logic [15:0] bias);
        int ht, vt, ft, p, h, v, fc;
        logic hsv, vsv, de, ls, fs, vbs;
        ht = hd + hf + hs + hb;
        vt = vd + vf + vs + vb;
        ft = ht * vt;
        if (k == 0) begin
            h = ht - 1; v = vt - 1; hsv = ~act; vsv = ~act; de = 1'b0;
            fc = 0; ls = 1'b0; fs = 1'b0; vbs = 1'b0;
        end else begin
            p   = (k - 1) % ft;
            h   = p % ht;
            v   = p / ht;
            hsv = (h >= hd + hf && h < hd + hf + hs) ? act : ~act;
            vsv = (v >= vd + vf && v < vd + vf + vs) ? act : ~act;
            de  = (h < hd) && (v < vd);
            fc  = (k - 1 >= vd * ht) ? ((k - 1 - vd * ht) / ft + 1) : 0;
            fc  = fc + int'(bias);
            ls  = a && (h == 0);
            fs  = a && (p == 0);
            vbs = a && (p == vd * ht);
        end
        return {hsv, vsv, de, 10'(h), 10'(v), 16'(fc), ls, fs, vbs};
    endfunction

    function automatic logic [41:0] exp_b();
        return model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, n, adv, 16'd0);
    endfunction

    function automatic logic [41:0] exp_s();
        return model(16, 4, 6, 4, 12, 2, 2, 3, 1'b1, n, adv, bias_s);
    endfunction

    wire [41:0] obs_b = {hs_b, vs_b, de_b, hp_b, vp_b, fc_b, ls_b, fs_b, vb_b};
    wire [41:0] obs_s = {hs_s, vs_s, de_s, hp_s, vp_s, fc_s, ls_s, fs_s, vb_s};

    task automatic tick(input bit c);
        ce = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        ce     = 1'b0;
        bias_s = 16'd0;
        @(posedge clk);
        #1;
        checks++;
        if ({hs_b, vs_b, de_b, hp_b, vp_b, fc_b, ls_b, fs_b, vb_b} !==
            {1'b1, 1'b1, 1'b0, 10'd799, 10'd524, 16'd0, 3'b000}) begin
            failures++;
            $display("FAIL reset_big: got=%h exp=%h", obs_b,
                     {1'b1, 1'b1, 1'b0, 10'd799, 10'd524, 16'd0, 3'b000});
        end
        checks++;
        if ({obs_b, obs_s} !== {exp_b(), exp_s()}) begin
            failures++;
            $display("FAIL reset_model: got=%h exp=%h", {obs_b, obs_s}, {exp_b(), exp_s()});
        end
        reset = 1'b0;
    endtask

    task automatic test_first_line();
        int hs_cnt = 0;
        int hs_first = -1;
        int hs_last = -1;
        for (int i = 1; i <= 1700; i++) begin
            tick(1'b1);
            checks++;
            if ({obs_b, obs_s} !== {exp_b(), exp_s()}) begin
                failures++;
                $display("FAIL line_cycle%0d: got=%h exp=%h", i, {obs_b, obs_s}, {exp_b(), exp_s()});
            end
            if (i <= 800 && hs_b == 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(hp_b);
                hs_last = int'(hp_b);
            end
            if (i == 1) begin
                checks++;
                if ({hp_b, vp_b, fs_b, ls_b, de_b, fc_b} !== {10'd0, 10'd0, 3'b111, 16'd0}) begin
                    failures++;
                    $display("FAIL first_pixel: got=%h exp=%h",
                             {hp_b, vp_b, fs_b, ls_b, de_b, fc_b}, {10'd0, 10'd0, 3'b111, 16'd0});
                end
            end
            if (i == 640 || i == 641) begin
                checks++;
                if (de_b !== (i == 640)) begin
                    failures++;
                    $display("FAIL display_edge hpos=%0d: got=%b exp=%b", hp_b, de_b, i == 640);
                end
            end
            if (i == 801) begin
                checks++;
                if ({ls_b, fs_b, hp_b, vp_b} !== {1'b1, 1'b0, 10'd0, 10'd1}) begin
                    failures++;
                    $display("FAIL second_line: got=%h exp=%h", {ls_b, fs_b, hp_b, vp_b},
                             {1'b1, 1'b0, 10'd0, 10'd1});
                end
            end
        end
        checks++;
        if (hs_cnt != 96 || hs_first != 656 || hs_last != 751) begin
            failures++;
            $display("FAIL hsync_window: got=%0d clks %0d..%0d exp=96 clks 656..751",
                     hs_cnt, hs_first, hs_last);
        end
    endtask

    task automatic test_frame();
        int fs_at[$];
        int vs_cnt = 0;
        for (int i = 0; i < 1300; i++) begin
            tick(1'b1);
            checks++;
            if ({obs_b, obs_s} !== {exp_b(), exp_s()}) begin
                failures++;
                $display("FAIL frame_cycle%0d: got=%h exp=%h", i, {obs_b, obs_s}, {exp_b(), exp_s()});
            end
            if (fs_s) fs_at.push_back(i);
            if (fs_at.size() == 1 && vs_s == 1'b1) vs_cnt++;
            if (vb_s) begin
                checks++;
                if ({ls_s, hp_s, vp_s} !== {1'b1, 10'd0, 10'd12}) begin
                    failures++;
                    $display("FAIL vblank_pos: got=%h exp=%h", {ls_s, hp_s, vp_s},
                             {1'b1, 10'd0, 10'd12});
                end
            end
        end
        checks++;
        if (fs_at.size() < 2) begin
            failures++;
            $display("FAIL frame_period: got=%0d frame starts exp>=2", fs_at.size());
        end else if (fs_at[1] - fs_at[0] != 570 || vs_cnt != 60) begin
            failures++;
            $display("FAIL frame_period: got=%0d clks vsync=%0d exp=570 clks vsync=60",
                     fs_at[1] - fs_at[0], vs_cnt);
        end
    endtask

    task automatic test_ce_toggle();
        bit prev_ls = 1'b0;
        bit found = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            if (i < 400) tick((i % 4 == 0) || (i % 4 == 3));
            else         tick(1'($urandom_range(0, 1)));
            checks++;
            if ({obs_b, obs_s} !== {exp_b(), exp_s()}) begin
                failures++;
                $display("FAIL ce_cycle%0d: got=%h exp=%h", i, {obs_b, obs_s}, {exp_b(), exp_s()});
            end
            checks++;
            if (ls_s && prev_ls) begin
                failures++;
                $display("FAIL strobe_width cycle%0d: got=2+ clks exp=1 clk", i);
            end
            prev_ls = ls_s;
        end
        for (int i = 0; i < 700 && !found; i++) begin
            tick(1'b1);
            found = fs_s;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL stall_seek: got=no frame_start exp=frame_start within 700 clks");
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0);
            checks++;
            if ({fs_s, ls_s, hp_s, vp_s} !== 22'd0 || {obs_b, obs_s} !== {exp_b(), exp_s()}) begin
                failures++;
                $display("FAIL stall_origin%0d: got=%h exp=%h", i, {obs_b, obs_s}, {exp_b(), exp_s()});
            end
        end
    endtask

    task automatic test_wrap();
        logic [41:0] m;
        bit seen = 1'b0;
        m = model(16, 4, 6, 4, 12, 2, 2, 3, 1'b1, n, adv, 16'd0);
        force dut_s.frame_cnt = 16'hFFFF;
        #1;
        release dut_s.frame_cnt;
        bias_s = 16'hFFFF - m[18:3];
        #1;
        checks++;
        if (fc_s !== 16'hFFFF) begin
            failures++;
            $display("FAIL wrap_preload: got=%h exp=ffff", fc_s);
        end
        for (int i = 0; i < 1200; i++) begin
            tick(1'b1);
            checks++;
            if ({obs_b, obs_s} !== {exp_b(), exp_s()}) begin
                failures++;
                $display("FAIL wrap_cycle%0d: got=%h exp=%h", i, {obs_b, obs_s}, {exp_b(), exp_s()});
            end
            if (vb_s && !seen) begin
                seen = 1'b1;
                checks++;
                if ({fc_s, hp_s, vp_s} !== {16'h0000, 10'd0, 10'd12}) begin
                    failures++;
                    $display("FAIL wrap_value: got=%h exp=%h", {fc_s, hp_s, vp_s},
                             {16'h0000, 10'd0, 10'd12});
                end
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL wrap_timeout: got=no vblank exp=vblank within 1200 clks");
        end
    endtask

    task automatic test_midframe_reset();
        int run = 37 + int'($urandom_range(0, 500));
        for (int i = 0; i < run; i++) tick(1'b1);
        #2;
        reset  = 1'b1;
        bias_s = 16'd0;
        #1;
        checks++;
        if ({hp_b, vp_b, hs_b, vs_b, fc_b, hp_s, vp_s, hs_s, vs_s, fc_s, ls_b, fs_b, de_s} !==
            {10'd799, 10'd524, 2'b11, 16'd0, 10'd29, 10'd18, 2'b00, 16'd0, 3'b000}) begin
            failures++;
            $display("FAIL async_reset: got=%h exp=%h",
                     {hp_b, vp_b, hs_b, vs_b, fc_b, hp_s, vp_s, hs_s, vs_s, fc_s, ls_b, fs_b, de_s},
                     {10'd799, 10'd524, 2'b11, 16'd0, 10'd29, 10'd18, 2'b00, 16'd0, 3'b000});
        end
        tick(1'b1);
        checks++;
        if ({obs_b, obs_s} !== {exp_b(), exp_s()}) begin
            failures++;
            $display("FAIL reset_hold: got=%h exp=%h", {obs_b, obs_s}, {exp_b(), exp_s()});
        end
        reset = 1'b0;
        tick(1'b1);
        checks++;
        if ({hp_b, vp_b, fs_b, ls_b, hp_s, vp_s, fs_s, ls_s} !==
            {10'd0, 10'd0, 2'b11, 10'd0, 10'd0, 2'b11} ||
            {obs_b, obs_s} !== {exp_b(), exp_s()}) begin
            failures++;
            $display("FAIL reset_release: got=%h exp=%h", {obs_b, obs_s}, {exp_b(), exp_s()});
        end
        for (int i = 0; i < 200; i++) begin
            tick(1'b1);
            checks++;
            if ({obs_b, obs_s} !== {exp_b(), exp_s()}) begin
                failures++;
                $display("FAIL post_reset%0d: got=%h exp=%h", i, {obs_b, obs_s}, {exp_b(), exp_s()});
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_frame();
        test_ce_toggle();
        test_wrap();
        test_midframe_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
